// File: rtl/lighthouse_pkg.sv
// Shared types and constants for the lighthouse pulse-capture path.
package lighthouse_pkg;

  localparam int TS_BITS  = 32;
  localparam int LEN_BITS = 16;

  typedef logic [1:0] sensor_idx_t;

  typedef struct packed {
    logic [TS_BITS-1:0]  ts;
    logic [LEN_BITS-1:0] length;
  } pulse_t;

  // Round-robin successor of idx among n channels, wrapping to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/pulse_slot.sv
// One-entry holding slot for a single sensor, with a saturating drop counter.
module pulse_slot #(
  parameter int TS_BITS   = 32,
  parameter int LEN_BITS  = 16,
  parameter int DROP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe,
  input  logic [TS_BITS-1:0]   in_ts,
  input  logic [LEN_BITS-1:0]  in_length,
  input  logic                 grant,
  input  logic                 clear_drops,
  output logic                 full,
  output logic [TS_BITS-1:0]   ts,
  output logic [LEN_BITS-1:0]  length,
  output logic [DROP_BITS-1:0] drop_count,
  output logic                 drop_nonzero_next
);

  localparam logic [DROP_BITS-1:0] DROP_MAX = {DROP_BITS{1'b1}};

  logic                 full_r;
  logic [TS_BITS-1:0]   ts_r;
  logic [LEN_BITS-1:0]  length_r;
  logic [DROP_BITS-1:0] drop_r;
  logic                 accept_s;
  logic                 drop_s;
  logic [DROP_BITS-1:0] drop_next_s;

  // A strobe is taken if the slot is empty or being drained this edge, else dropped.
  always_comb begin
    accept_s = 1'b0;
    drop_s   = 1'b0;
    if (strobe) begin
      if (!full_r || grant) begin
        accept_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  // Next drop count: clear wins over increment but still records a same-edge drop.
  always_comb begin
    drop_next_s = drop_r;
    if (clear_drops) begin
      drop_next_s = drop_s ? {{(DROP_BITS-1){1'b0}}, 1'b1} : {DROP_BITS{1'b0}};
    end else if (drop_s && (drop_r != DROP_MAX)) begin
      drop_next_s = drop_r + {{(DROP_BITS-1){1'b0}}, 1'b1};
    end else begin
      drop_next_s = drop_r;
    end
  end

  // Slot storage and full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_r   <= 1'b0;
      ts_r     <= {TS_BITS{1'b0}};
      length_r <= {LEN_BITS{1'b0}};
    end else if (accept_s) begin
      full_r   <= 1'b1;
      ts_r     <= in_ts;
      length_r <= in_length;
    end else if (grant) begin
      full_r   <= 1'b0;
    end else begin
      full_r   <= full_r;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_r <= {DROP_BITS{1'b0}};
    end else begin
      drop_r <= drop_next_s;
    end
  end

  assign full              = full_r;
  assign ts                = ts_r;
  assign length            = length_r;
  assign drop_count        = drop_r;
  assign drop_nonzero_next = |drop_next_s;

endmodule

// File: rtl/pulse_merge_arbiter.sv
// Merges per-sensor pulse strobes into one registered valid/ready stream
// using round-robin arbitration across one-entry holding slots.
module pulse_merge_arbiter #(
  parameter int N_SENSORS   = 4,
  parameter int SENSOR_BITS = 2,
  parameter int TS_BITS     = lighthouse_pkg::TS_BITS,
  parameter int LEN_BITS    = lighthouse_pkg::LEN_BITS,
  parameter int DROP_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_SENSORS-1:0]           sensor_valid,
  input  logic [N_SENSORS*TS_BITS-1:0]   sensor_ts,
  input  logic [N_SENSORS*LEN_BITS-1:0]  sensor_length,
  input  logic [N_SENSORS-1:0]           channel_enable,
  output logic                           out_valid,
  output logic [TS_BITS-1:0]             out_ts,
  output logic [LEN_BITS-1:0]            out_length,
  output logic [SENSOR_BITS-1:0]         out_sensor,
  input  logic                           out_ready,
  input  logic                           clear_drops,
  output logic [N_SENSORS*DROP_BITS-1:0] drop_count,
  output logic                           overflow
);

  import lighthouse_pkg::*;

  logic [N_SENSORS-1:0] slot_full_s;
  logic [N_SENSORS-1:0] slot_grant_s;
  logic [N_SENSORS-1:0] slot_nonzero_s;
  logic [TS_BITS-1:0]   slot_ts_s     [N_SENSORS];
  logic [LEN_BITS-1:0]  slot_length_s [N_SENSORS];

  logic                   out_valid_r;
  logic [TS_BITS-1:0]     out_ts_r;
  logic [LEN_BITS-1:0]    out_length_r;
  logic [SENSOR_BITS-1:0] out_sensor_r;
  logic [SENSOR_BITS-1:0] rr_ptr_r;
  logic                   overflow_r;

  logic                   load_en_s;
  logic                   grant_found_s;
  logic [SENSOR_BITS-1:0] grant_idx_s;
  logic [SENSOR_BITS-1:0] rr_after_s;

  genvar gi;
  generate
    for (gi = 0; gi < N_SENSORS; gi++) begin : g_slot
      pulse_slot #(
        .TS_BITS  (TS_BITS),
        .LEN_BITS (LEN_BITS),
        .DROP_BITS(DROP_BITS)
      ) u_slot (
        .clk              (clk),
        .reset            (reset),
        .strobe           (sensor_valid[gi] && channel_enable[gi]),
        .in_ts            (sensor_ts[gi*TS_BITS +: TS_BITS]),
        .in_length        (sensor_length[gi*LEN_BITS +: LEN_BITS]),
        .grant            (slot_grant_s[gi]),
        .clear_drops      (clear_drops),
        .full             (slot_full_s[gi]),
        .ts               (slot_ts_s[gi]),
        .length           (slot_length_s[gi]),
        .drop_count       (drop_count[gi*DROP_BITS +: DROP_BITS]),
        .drop_nonzero_next(slot_nonzero_s[gi])
      );
    end
  endgenerate

  // The output register may accept a new entry when empty or being drained.
  assign load_en_s = !out_valid_r || out_ready;

  // Round-robin priority encoder: first full slot at or after rr_ptr.
  always_comb begin
    int unsigned cand;
    grant_found_s = 1'b0;
    grant_idx_s   = {SENSOR_BITS{1'b0}};
    cand          = 32'd0;
    for (int k = 0; k < N_SENSORS; k++) begin
      cand = int'(rr_ptr_r) + k;
      if (cand >= N_SENSORS) begin
        cand = cand - N_SENSORS;
      end else begin
        cand = cand;
      end
      if (!grant_found_s && slot_full_s[cand]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = SENSOR_BITS'(cand);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer value that follows the granted slot.
  assign rr_after_s = SENSOR_BITS'(rr_next(int'(grant_idx_s), N_SENSORS));

  // One-hot drain strobe back to the winning slot.
  always_comb begin
    slot_grant_s = {N_SENSORS{1'b0}};
    for (int k = 0; k < N_SENSORS; k++) begin
      if (load_en_s && grant_found_s && (grant_idx_s == SENSOR_BITS'(k))) begin
        slot_grant_s[k] = 1'b1;
      end else begin
        slot_grant_s[k] = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; holds contents while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_ts_r     <= {TS_BITS{1'b0}};
      out_length_r <= {LEN_BITS{1'b0}};
      out_sensor_r <= {SENSOR_BITS{1'b0}};
      rr_ptr_r     <= {SENSOR_BITS{1'b0}};
    end else if (load_en_s) begin
      if (grant_found_s) begin
        out_valid_r  <= 1'b1;
        out_ts_r     <= slot_ts_s[grant_idx_s];
        out_length_r <= slot_length_s[grant_idx_s];
        out_sensor_r <= grant_idx_s;
        rr_ptr_r     <= rr_after_s;
      end else begin
        out_valid_r  <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Overflow flag tracks the counters' next state so it lines up with drop_count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= |slot_nonzero_s;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_ts     = out_ts_r;
  assign out_length = out_length_r;
  assign out_sensor = out_sensor_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_pulse_merge_arbiter.sv
// Directed self-checking bench for pulse_merge_arbiter.
module tb_pulse_merge_arbiter;

  localparam int N  = 4;
  localparam int TW = 32;
  localparam int LW = 16;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  sensor_valid;
  logic [N*TW-1:0] sensor_ts;
  logic [N*LW-1:0] sensor_length;
  logic [N-1:0]  channel_enable;
  logic          out_valid;
  logic [TW-1:0] out_ts;
  logic [LW-1:0] out_length;
  logic [1:0]    out_sensor;
  logic          out_ready;
  logic          clear_drops;
  logic [N*DW-1:0] drop_count;
  logic          overflow;

  int total;
  int bad;

  pulse_merge_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_valid  (sensor_valid),
    .sensor_ts     (sensor_ts),
    .sensor_length (sensor_length),
    .channel_enable(channel_enable),
    .out_valid     (out_valid),
    .out_ts        (out_ts),
    .out_length    (out_length),
    .out_sensor    (out_sensor),
    .out_ready     (out_ready),
    .clear_drops   (clear_drops),
    .drop_count    (drop_count),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sensor_valid   = '0;
    sensor_ts      = '0;
    sensor_length  = '0;
    channel_enable = '1;
    out_ready      = 1'b1;
    clear_drops    = 1'b0;
    reset          = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_pulse(input int s, input logic [TW-1:0] t, input logic [LW-1:0] l);
    sensor_valid[s]          = 1'b1;
    sensor_ts[s*TW +: TW]    = t;
    sensor_length[s*LW +: LW] = l;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_ts !== 32'h0 || out_length !== 16'h0 || out_sensor !== 2'd0) begin
      $display("FAIL reset_out: valid=%b ts=%h len=%h sensor=%0d want all zero", out_valid, out_ts, out_length, out_sensor);
      bad++;
    end
    total++;
    if (drop_count !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL reset_drops: drops=%h ovf=%b want 0/0", drop_count, overflow);
      bad++;
    end
  endtask

  task automatic test_single();
    do_reset();
    set_pulse(2, 32'h100, 16'h20);
    tick();
    sensor_valid = '0;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_latency: out_valid=%b want 0", out_valid);
      bad++;
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_sensor !== 2'd2 || out_ts !== 32'h100 || out_length !== 16'h20) begin
      $display("FAIL single_out: valid=%b sensor=%0d ts=%h len=%h want 1/2/100/20", out_valid, out_sensor, out_ts, out_length);
      bad++;
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_done: out_valid=%b want 0", out_valid);
      bad++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int s = 0; s < N; s++) set_pulse(s, 32'hA000 + 32'(s), 16'h10 + 16'(s));
    tick();
    sensor_valid = '0;
    for (int s = 0; s < N; s++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sensor !== 2'(s) || out_ts !== 32'hA000 + 32'(s) || out_length !== 16'h10 + 16'(s)) begin
        $display("FAIL simul_order%0d: valid=%b sensor=%0d ts=%h len=%h want 1/%0d/%h/%h", s, out_valid, out_sensor, out_ts, out_length, s, 32'hA000 + 32'(s), 16'h10 + 16'(s));
        bad++;
      end
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL simul_drain: out_valid=%b want 0", out_valid);
      bad++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    set_pulse(1, 32'h11, 16'h1);
    tick();
    sensor_valid = '0;
    tick();
    set_pulse(1, 32'h22, 16'h2);
    tick();
    set_pulse(1, 32'h33, 16'h3);
    tick();
    sensor_valid = '0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_ts !== 32'h11 || out_sensor !== 2'd1) begin
      $display("FAIL bp_hold: valid=%b ts=%h sensor=%0d want 1/11/1", out_valid, out_ts, out_sensor);
      bad++;
    end
    total++;
    if (drop_count[1*DW +: DW] !== 8'd1 || overflow !== 1'b1) begin
      $display("FAIL bp_drop: drop1=%0d ovf=%b want 1/1", drop_count[1*DW +: DW], overflow);
      bad++;
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_ts !== 32'h22 || out_length !== 16'h2) begin
      $display("FAIL bp_second: valid=%b ts=%h len=%h want 1/22/2", out_valid, out_ts, out_length);
      bad++;
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
      bad++;
    end
  endtask

  task automatic test_refill();
    do_reset();
    set_pulse(0, 32'h500, 16'h5);
    tick();
    set_pulse(0, 32'h600, 16'h6);
    tick();
    sensor_valid = '0;
    total++;
    if (out_valid !== 1'b1 || out_ts !== 32'h500) begin
      $display("FAIL refill_first: valid=%b ts=%h want 1/500", out_valid, out_ts);
      bad++;
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_ts !== 32'h600 || out_length !== 16'h6 || out_sensor !== 2'd0) begin
      $display("FAIL refill_second: valid=%b ts=%h len=%h sensor=%0d want 1/600/6/0", out_valid, out_ts, out_length, out_sensor);
      bad++;
    end
    total++;
    if (drop_count !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL refill_nodrop: drops=%h ovf=%b want 0/0", drop_count, overflow);
      bad++;
    end
  endtask

  task automatic test_disabled();
    do_reset();
    channel_enable = 4'b1011;
    set_pulse(2, 32'h777, 16'h7);
    tick();
    sensor_valid = '0;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || drop_count !== 32'h0) begin
      $display("FAIL disabled_ignore: valid=%b drops=%h want 0/0", out_valid, drop_count);
      bad++;
    end
    channel_enable = '1;
  endtask

  task automatic test_fairness();
    do_reset();
    out_ready = 1'b1;
    // Keep every slot refilled each cycle; grants must rotate 0,1,2,3,0,1,...
    sensor_valid = '1;
    tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_sensor !== 2'(c % N)) begin
        $display("FAIL fair_cycle%0d: valid=%b sensor=%0d want 1/%0d", c, out_valid, out_sensor, c % N);
        bad++;
      end
    end
    sensor_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    set_pulse(3, 32'h3333, 16'h33);
    // First edge fills the slot, second drains it into the output and refills, then 300 drops.
    for (int c = 0; c < 302; c++) tick();
    sensor_valid = '0;
    tick();
    total++;
    if (drop_count[3*DW +: DW] !== 8'd255 || overflow !== 1'b1) begin
      $display("FAIL sat_max: drop3=%0d ovf=%b want 255/1", drop_count[3*DW +: DW], overflow);
      bad++;
    end
    clear_drops = 1'b1;
    tick();
    clear_drops = 1'b0;
    total++;
    if (drop_count !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL sat_clear: drops=%h ovf=%b want 0/0", drop_count, overflow);
      bad++;
    end
    clear_drops  = 1'b1;
    sensor_valid = 4'b1000;
    tick();
    clear_drops  = 1'b0;
    sensor_valid = '0;
    total++;
    if (drop_count[3*DW +: DW] !== 8'd1 || overflow !== 1'b1) begin
      $display("FAIL sat_clear_drop: drop3=%0d ovf=%b want 1/1", drop_count[3*DW +: DW], overflow);
      bad++;
    end
  endtask

  task automatic test_reset_midstream();
    // Continues from saturation: output stalled with valid=1 and slot 3 full.
    set_pulse(0, 32'h9, 16'h9);
    tick();
    sensor_valid = '0;
    total++;
    if (out_valid !== 1'b1) begin
      $display("FAIL mid_precond: out_valid=%b want 1", out_valid);
      bad++;
    end
    reset = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || out_ts !== 32'h0 || out_length !== 16'h0 || out_sensor !== 2'd0 || drop_count !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL mid_reset: valid=%b ts=%h len=%h sensor=%0d drops=%h ovf=%b want all zero", out_valid, out_ts, out_length, out_sensor, drop_count, overflow);
      bad++;
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        $display("FAIL mid_stale%0d: out_valid=%b want 0", c, out_valid);
        bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_refill();
    test_disabled();
    test_fairness();
    test_saturation();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
